spi_mem_master: RTL and testbench
=================================

# spi_mem_master

SPI master that sequences read and write transactions into the on-board `spiMemory` slave, so that fabric logic (switch/button handlers, test sequencers) can access the slave through a simple request/done handshake instead of bit-banging GPIO. It sits in the `mp2` top level. Its `sclk`, `cs` and `mosi` drive the slave's serial inputs, and `miso` is returned from the slave's serial output. Each transaction is one 16-bit frame: 7-bit address, 1 R/W bit, then 8 data bits, MSB first, in SPI mode 0.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period; legal values are ≥ 4.
- `ADDR_W`, default 7: address width; fixed at 7 by the slave.
- `DATA_W`, default 8: data width; fixed at 8 by the slave.
- `clk` input, 1 bit: system clock; all logic is on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, 1 bit: transaction request; sampled only while `ready`=1.
- `wr` input, 1 bit: 1 = write, 0 = read; captured when a request is accepted.
- `addr` input, `ADDR_W` bits: target address; captured when a request is accepted.
- `wdata` input, `DATA_W` bits: write data; captured when a request is accepted.
- `ready` output, 1 bit: 1 in IDLE, meaning a new request can be accepted.
- `busy` output, 1 bit: equals `~ready`.
- `done` output, 1 bit: one-cycle pulse at the end of every transaction.
- `rdata` output, `DATA_W` bits: read result; updated only at `done` of a read, and held otherwise.
- `sclk` output, 1 bit: serial clock; idles low.
- `cs` output, 1 bit: chip select, active low; idles high.
- `mosi` output, 1 bit: serial data to the slave.
- `miso` input, 1 bit: serial data from the slave; asynchronous to `clk`.

## Operation
- Acceptance: a rising edge with `req`=1 and `ready`=1 accepts the request.
  - On that edge the block loads the shift register with `{addr, ~wr, wr ? wdata : 8'h00}`. The R/W bit is 1 for a read.
  - On that edge the block enters SETUP.
- States:
  - IDLE: `cs`=1, `sclk`=0, `mosi`=0.
  - SETUP: `cs`=0, `sclk`=0, `mosi`=MSB of the frame. Lasts CLK_DIV cycles, then goes to SHIFT.
  - SHIFT: 16 `sclk` periods. Each period is a high half then a low half, each CLK_DIV cycles.
    - On each `sclk` rising edge the synchronized `miso` is shifted into bit 0 of `rx`.
    - On each falling edge `mosi` advances to the next frame bit.
    - After the 16th falling edge the state goes to HOLD.
  - HOLD: `cs`=0, `sclk`=0 for CLK_DIV cycles, then DONE.
  - DONE: one cycle. `cs`=1 and `done`=1. For a read, `rdata`←`rx[7:0]` (the last 8 sampled bits). Then IDLE.
- `miso` passes through a 2-flop synchronizer before sampling. This is safe because the slave changes `miso` on falling edges, at least CLK_DIV cycles before the sample point.
- `req` while busy is ignored, with no queuing.
- A `req` held high through `done` is re-accepted on the first IDLE cycle.
- A bit counter (0..15) and a divider counter (0..CLK_DIV−1) both clear on acceptance.

## Timing
- Reset values (held while `reset_n`=0): state=IDLE, `cs`=1, `sclk`=0, `mosi`=0, `ready`=1, `busy`=0, `done`=0, `rdata`=0, and shift/rx registers = 0.
- Reset asserted mid-transaction aborts immediately, with no trailing `sclk` edge. `done` is not issued.
- Latency from the acceptance edge:
  - `cs` falls 1 cycle after acceptance.
  - First `sclk` rise occurs at cycle 1+CLK_DIV.
  - `done` is high in cycle 1+34·CLK_DIV (137 for CLK_DIV=4).
  - `ready` returns the cycle after `done`.
- Minimum request-to-request spacing is 2+34·CLK_DIV cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `spi_mem_pkg` holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, DONE);
  - `FRAME_BITS`=16;
  - `RW_BIT_POS`=8 (bit index in the frame);
  - `RW_READ`=1.
- Sub-module `spi_clk_div`, parameterized by CLK_DIV:
  - inputs: `clk`, `reset_n`, `en`, `clr`;
  - output: a one-cycle `tick` every CLK_DIV enabled cycles.
  - The FSM advances half-phases on `tick`.

## Test plan
- Write: addr=7'h05, wdata=8'hA5, CLK_DIV=4.
  - The bench decodes 16 bits on `sclk` rising edges: 8'h0A, then 8'hA5.
  - `done` is high at cycle 137.
  - `rdata` keeps its prior value.
- Read: addr=7'h05, with the slave model returning 8'h3C in the data phase.
  - Decoded header is 8'h0B and `mosi`=0 during the data phase.
  - `rdata`=8'h3C at `done`.
- Back-to-back: `req` held high for 3 transactions.
  - Exactly 3 `done` pulses, spaced 138 cycles apart.
  - `cs` is high for exactly 1 cycle (the DONE cycle) plus 1 cycle (IDLE) between frames.
- Ignore while busy: pulse `req` with a different addr/wdata in mid-SHIFT.
  - Only the original frame appears on `mosi`.
  - No extra `done`.
- Reset mid-frame: assert `reset_n`=0 after the 6th `sclk` rise.
  - `cs`=1, `sclk`=0, `mosi`=0 immediately.
  - No `done`.
  - After release, `ready`=1 and a new read completes correctly.
- CLK_DIV=6: repeat the read.
  - `sclk` high and low halves are each 6 cycles.
  - `done` is high at cycle 205.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared constants and frame layout for the spiMemory SPI master.
package spi_mem_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned RW_BIT_POS = 8;
    localparam logic        RW_READ    = 1'b1;
    localparam int unsigned STATE_W    = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // One serial frame, MSB first: address, R/W (1 = read), data.
    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } frame_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: registered one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // tick is raised one cycle early so it lands on the last cycle of each period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_W'(CLK_DIV - 2));
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master issuing one 16-bit read/write frame per request to spiMemory.
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    state_t                  state, state_nxt;
    logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
    logic [DATA_W-1:0]       rx, rx_nxt;
    logic [DATA_W-1:0]       rdata_nxt;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic                    is_read, is_read_nxt;
    logic                    cs_nxt, sclk_nxt, mosi_nxt, done_nxt, ready_nxt, busy_nxt;
    logic                    miso_meta, miso_sync;
    logic                    tick;
    logic                    div_en_c, div_clr_c;
    frame_t                  load_c;

    assign div_en_c  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign div_clr_c = (state == ST_IDLE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (div_en_c),
        .clr     (div_clr_c),
        .tick    (tick)
    );

    // miso is asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            rx      <= '0;
            rdata   <= '0;
            bit_cnt <= '0;
            is_read <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            rx      <= rx_nxt;
            rdata   <= rdata_nxt;
            bit_cnt <= bit_cnt_nxt;
            is_read <= is_read_nxt;
            cs      <= cs_nxt;
            sclk    <= sclk_nxt;
            mosi    <= mosi_nxt;
            done    <= done_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered from the *_nxt values.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        rx_nxt      = rx;
        rdata_nxt   = rdata;
        bit_cnt_nxt = bit_cnt;
        is_read_nxt = is_read;
        cs_nxt      = cs;
        sclk_nxt    = sclk;
        mosi_nxt    = mosi;
        done_nxt    = 1'b0;
        ready_nxt   = ready;
        busy_nxt    = busy;

        load_c.addr = addr;
        load_c.rw   = ~wr;
        load_c.data = wr ? wdata : '0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt   = ST_SETUP;
                    shreg_nxt   = load_c;
                    rx_nxt      = '0;
                    bit_cnt_nxt = '0;
                    is_read_nxt = ~wr;
                    cs_nxt      = 1'b0;
                    mosi_nxt    = load_c[FRAME_BITS-1];
                    ready_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_nxt = ST_SHIFT;
                    sclk_nxt  = 1'b1;
                    rx_nxt    = {rx[DATA_W-2:0], miso_sync};
                end
            end
            ST_SHIFT: begin
                // bit_cnt indexes the current sclk period; the last low half ends the frame
                if (tick) begin
                    if (sclk) begin
                        sclk_nxt  = 1'b0;
                        shreg_nxt = shreg << 1;
                        mosi_nxt  = shreg[FRAME_BITS-2];
                    end else if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        sclk_nxt    = 1'b1;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        rx_nxt      = {rx[DATA_W-2:0], miso_sync};
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_nxt = ST_DONE;
                    cs_nxt    = 1'b1;
                    mosi_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    if (is_read == RW_READ) begin
                        rdata_nxt = rx;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cs_nxt    = 1'b1;
                sclk_nxt  = 1'b0;
                mosi_nxt  = 1'b0;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Self-checking bench: two masters (CLK_DIV 4 and 6) against a behavioural SPI slave and frame model.
module tb_spi_mem_master;

    localparam int unsigned CD0 = 4;
    localparam int unsigned CD1 = 6;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       req   [2];
    logic       wr    [2];
    logic [6:0] addr  [2];
    logic [7:0] wdata [2];
    logic       ready [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] rdata [2];
    logic       sclk  [2];
    logic       cs    [2];
    logic       mosi  [2];
    logic       miso  [2];

    always #5 clk = ~clk;

    spi_mem_master #(.CLK_DIV(CD0), .ADDR_W(7), .DATA_W(8)) u0 (
        .clk(clk), .reset_n(rst_n[0]), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0]),
        .rdata(rdata[0]), .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    spi_mem_master #(.CLK_DIV(CD1), .ADDR_W(7), .DATA_W(8)) u1 (
        .clk(clk), .reset_n(rst_n[1]), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1]),
        .rdata(rdata[1]), .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    int tests = 0;
    int fails = 0;

    // Monitor / slave state, written only by the negedge process
    int          ncyc = 0;
    int          rel [2], done_cnt [2], done_rel [2], ready_rel [2], rise_rel [2];
    int          nbits [2], sidx [2], run_len [2], cs_hi_len [2], cs_gap [2];
    int          hi_min [2], hi_max [2], lo_min [2], lo_max [2];
    int          bad_busy [2], last_done [2], done_gap [2];
    logic [15:0] frame_rx [2];
    logic        p_ready [2], p_sclk [2], p_cs [2];

    // Slave response bytes, written only by the stimulus process
    logic [7:0]  rd_byte [2];
    logic [7:0]  junk    [2];
    logic [7:0]  exp_rd  [2];

    function automatic logic resp_bit(input int g, input int i);
        logic [15:0] w;
        w = {junk[g], rd_byte[g]};
        return (i < 16) ? w[15-i] : 1'b0;
    endfunction

    // Mode-0 slave: drives miso on cs fall and each sclk fall, captures mosi on sclk rise
    always @(negedge clk) begin
        ncyc++;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n[g]) begin
                rel[g] = 0; p_ready[g] = 1'b1; p_sclk[g] = 1'b0; p_cs[g] = 1'b1;
                miso[g] = 1'b0; cs_hi_len[g] = 0;
            end else begin
                if (busy[g] !== ~ready[g]) bad_busy[g]++;
                if (p_ready[g] && !ready[g]) rel[g] = 1;
                else if (rel[g] > 0) rel[g]++;
                if (!p_ready[g] && ready[g] && rel[g] > 0) ready_rel[g] = rel[g];
                if (done[g]) begin
                    done_cnt[g]++;
                    done_rel[g]  = rel[g];
                    done_gap[g]  = ncyc - last_done[g];
                    last_done[g] = ncyc;
                end
                if (cs[g]) cs_hi_len[g]++;
                if (p_cs[g] && !cs[g]) begin
                    cs_gap[g] = cs_hi_len[g]; cs_hi_len[g] = 0;
                    nbits[g] = 0; sidx[g] = 0; run_len[g] = 1;
                    miso[g] = resp_bit(g, 0);
                    hi_min[g] = 1000; hi_max[g] = 0; lo_min[g] = 1000; lo_max[g] = 0;
                end else if (!cs[g]) begin
                    if (sclk[g] == p_sclk[g]) begin
                        run_len[g]++;
                    end else begin
                        if (p_sclk[g]) begin
                            if (run_len[g] < hi_min[g]) hi_min[g] = run_len[g];
                            if (run_len[g] > hi_max[g]) hi_max[g] = run_len[g];
                        end else begin
                            if (run_len[g] < lo_min[g]) lo_min[g] = run_len[g];
                            if (run_len[g] > lo_max[g]) lo_max[g] = run_len[g];
                        end
                        run_len[g] = 1;
                        if (sclk[g]) begin
                            if (nbits[g] == 0) rise_rel[g] = rel[g];
                            frame_rx[g] = {frame_rx[g][14:0], mosi[g]};
                            nbits[g]++;
                        end else begin
                            sidx[g]++;
                            miso[g] = resp_bit(g, sidx[g]);
                        end
                    end
                end
                p_ready[g] = ready[g]; p_sclk[g] = sclk[g]; p_cs[g] = cs[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One request; optional mid-frame competing request; then model checks
    task automatic run_txn(input int g, input logic w, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] rb, input int poke_at);
        int          d0;
        int          cd;
        logic [15:0] exp_frame;
        cd = (g == 0) ? CD0 : CD1;
        @(posedge clk); #1;
        rd_byte[g] = rb; junk[g] = 8'($urandom);
        wr[g] = w; addr[g] = a; wdata[g] = d; req[g] = 1'b1;
        d0 = done_cnt[g];
        chk("ready_before_req", 32'(ready[g]), 1);
        @(posedge clk); #1;
        req[g] = 1'b0; addr[g] = 7'($urandom); wdata[g] = 8'($urandom); wr[g] = ~w;
        if (poke_at > 0) begin
            repeat (poke_at) @(posedge clk);
            #1; req[g] = 1'b1; addr[g] = a ^ 7'h7F; wdata[g] = ~d;
            @(posedge clk); #1; req[g] = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt[g] == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        if (poke_at > 0) repeat (250) @(posedge clk);
        #1;
        exp_frame = {a, ~w, w ? d : 8'h00};
        if (!w) exp_rd[g] = rb;
        chk("done_count", 32'(done_cnt[g] - d0), 1);
        chk("frame", 32'(frame_rx[g]), 32'(exp_frame));
        chk("nbits", 32'(nbits[g]), 16);
        chk("done_latency", 32'(done_rel[g]), 32'(1 + 34 * cd));
        chk("first_rise", 32'(rise_rel[g]), 32'(1 + cd));
        chk("ready_return", 32'(ready_rel[g]), 32'(2 + 34 * cd));
        chk("rdata", 32'(rdata[g]), 32'(exp_rd[g]));
        chk("sclk_hi_min", 32'(hi_min[g]), cd);
        chk("sclk_hi_max", 32'(hi_max[g]), cd);
        chk("sclk_lo_min", 32'(lo_min[g]), cd);
        chk("sclk_lo_max", 32'(lo_max[g]), cd);
        chk("idle_cs", 32'({cs[g], sclk[g], mosi[g], ready[g]}), 32'b1001);
    endtask

    initial begin
        int d0;
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0; req[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
            rd_byte[g] = '0; junk[g] = '0; exp_rd[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs", 32'(cs[g]), 1);
            chk("rst_sclk", 32'(sclk[g]), 0);
            chk("rst_mosi", 32'(mosi[g]), 0);
            chk("rst_ready", 32'(ready[g]), 1);
            chk("rst_busy", 32'(busy[g]), 0);
            chk("rst_done", 32'(done[g]), 0);
            chk("rst_rdata", 32'(rdata[g]), 0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (2) @(posedge clk);

        // Directed write then read at address 5
        run_txn(0, 1'b1, 7'h05, 8'hA5, 8'h77, 0);
        chk("wr_header", 32'(frame_rx[0][15:8]), 32'h0A);
        chk("wr_data", 32'(frame_rx[0][7:0]), 32'hA5);
        chk("wr_rdata_held", 32'(rdata[0]), 0);
        chk("wr_done_137", 32'(done_rel[0]), 137);
        run_txn(0, 1'b0, 7'h05, 8'hFF, 8'h3C, 0);
        chk("rd_header", 32'(frame_rx[0][15:8]), 32'h0B);
        chk("rd_mosi_data", 32'(frame_rx[0][7:0]), 0);
        chk("rd_rdata", 32'(rdata[0]), 32'h3C);

        // Randomized transactions
        for (int k = 0; k < 6; k++)
            run_txn(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0);

        // Competing request during SHIFT is ignored
        run_txn(0, 1'b1, 7'h2A, 8'h96, 8'h00, 40);

        // Back-to-back: req held for three frames
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 7'h33; wdata[0] = 8'hC3; req[0] = 1'b1;
        d0 = done_cnt[0];
        for (int i = 0; i < 700 && done_cnt[0] - d0 < 2; i++) @(posedge clk);
        chk("b2b_two_done", 32'(done_cnt[0] - d0), 2);
        chk("b2b_gap1", 32'(done_gap[0]), 138);
        chk("b2b_cs_gap1", 32'(cs_gap[0]), 2);
        @(posedge clk); #1; req[0] = 1'b0;
        for (int i = 0; i < 400 && done_cnt[0] - d0 < 3; i++) @(posedge clk);
        chk("b2b_gap2", 32'(done_gap[0]), 138);
        chk("b2b_cs_gap2", 32'(cs_gap[0]), 2);
        repeat (300) @(posedge clk);
        #1;
        chk("b2b_three_done", 32'(done_cnt[0] - d0), 3);
        chk("b2b_frame", 32'(frame_rx[0]), 32'({7'h33, 1'b0, 8'hC3}));
        chk("b2b_rdata_held", 32'(rdata[0]), 32'(exp_rd[0]));

        // Reset after the 6th sclk rise aborts the frame
        @(posedge clk); #1;
        wr[0] = 1'b0; addr[0] = 7'h12; wdata[0] = 8'h00; rd_byte[0] = 8'hE1; req[0] = 1'b1;
        d0 = done_cnt[0];
        @(posedge clk); #1; req[0] = 1'b0;
        for (int i = 0; i < 300 && !(cs[0] == 1'b0 && nbits[0] == 6); i++) @(posedge clk);
        chk("rst_wait_6_rises", 32'(nbits[0]), 6);
        #2; rst_n[0] = 1'b0;
        #1;
        chk("abort_cs", 32'(cs[0]), 1);
        chk("abort_sclk", 32'(sclk[0]), 0);
        chk("abort_mosi", 32'(mosi[0]), 0);
        repeat (3) @(posedge clk);
        #1; rst_n[0] = 1'b1; exp_rd[0] = 8'h00;
        repeat (150) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt[0] - d0), 0);
        chk("abort_ready", 32'(ready[0]), 1);
        chk("abort_rdata", 32'(rdata[0]), 0);
        run_txn(0, 1'b0, 7'h05, 8'h00, 8'h5B, 0);

        // CLK_DIV = 6 instance
        run_txn(1, 1'b0, 7'h05, 8'h00, 8'h3C, 0);
        chk("cd6_done_205", 32'(done_rel[1]), 205);
        chk("cd6_rdata", 32'(rdata[1]), 32'h3C);
        for (int k = 0; k < 3; k++)
            run_txn(1, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0);

        chk("busy_is_not_ready0", 32'(bad_busy[0]), 0);
        chk("busy_is_not_ready1", 32'(bad_busy[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
